prbs9_checker: RTL and testbench
================================

# prbs9_checker

Receive-side companion to the PRBS9 generator: monitors a serial bit stream for the x^9 + x^5 + 1 sequence. It self-synchronizes to the stream, declares lock after a run of correct bits, then free-runs a local reference and counts bit errors. It drops lock when the error density gets too high. It sits at the far end of the link/channel under test and feeds status/BER counters to the register bank.

## Interface
- `LOCK_CNT`, 32: consecutive correctly predicted bits (after history fill) required to declare lock; range 1..255.
- `WIN_LEN`, 64: length in accepted bits of the loss-of-lock observation window; range 2..1024.
- `UNLOCK_ERRS`, 8: errors within one window that force loss of lock; range 1..`WIN_LEN`.
- `CNT_W`, 32: width of the bit and error counters.

- `clk`, input, 1: clock; all logic on rising edge.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_en`, input, 1: enable; a bit is accepted only when `i_en` && `i_valid`.
- `i_valid`, input, 1: `i_data` valid this cycle.
- `i_data`, input, 1: received serial bit.
- `i_clr`, input, 1: synchronous clear of `o_bit_cnt`/`o_err_cnt` only; lock state unaffected.
- `o_lock`, output, 1: checker locked.
- `o_err`, output, 1: one-cycle pulse per errored bit while locked.
- `o_bit_cnt`, output, `CNT_W`: bits checked while locked, saturating.
- `o_err_cnt`, output, `CNT_W`: errored bits while locked, saturating.

## Operation
- Sequence definition: `b[n+9] = b[n] ^ b[n+4]`; identical to generator output `register[8]` with update `{r[7:0], r[8]^r[4]}`.
- History `h[8:0]`: `h[0]` is the newest accepted bit, `h[8]` is 9 bits old. Self-sync prediction is `p_s = h[8]^h[4]`.
- FSM states: FILL, SEARCH, LOCKED. Reset state is FILL.
- FILL:
  - Each accepted bit shifts into `h` and increments the fill counter.
  - After the 9th accepted bit, go to SEARCH.
- SEARCH:
  - Each accepted bit is compared with `p_s`, then shifted into `h`.
  - The match counter increments on a match and clears to 0 on a mismatch.
  - If the updated `h` is all-zero, the match counter clears to 0 (forbidden state, never locks).
  - When the match counter reaches `LOCK_CNT`, go to LOCKED. The local generator `g` is loaded with the updated `h` (including the current bit).
- LOCKED:
  - Prediction is `p_l = g[8]^g[4]`.
  - On each accepted bit, `g` shifts in `p_l` (never the received bit), so one line error gives exactly one counted error.
  - `err = i_data != p_l`.
  - Every accepted bit increments `o_bit_cnt`; every `err` increments `o_err_cnt` and pulses `o_err`.
- Window (LOCKED only):
  - The window bit counter counts accepted bits and the window error counter counts errors.
  - If an error makes the window error count reach `UNLOCK_ERRS`, go to FILL next cycle. Clear the fill, match and window counters.
  - Otherwise, on the `WIN_LEN`-th accepted bit of the window, both window counters restart at 0.
- No accepted bit (`i_en`=0 or `i_valid`=0): all state holds, `o_err`=0.
- Counters saturate at 2^`CNT_W`-1 and do not wrap.
- `i_clr` together with an accepted bit: the clear wins, the bit is not counted, and the counters read 0 next cycle. Lock and window logic still process the bit.
- Reset mid-operation: return to FILL immediately and discard history and `g`.

## Timing
- Reset values: `o_lock`=0, `o_err`=0, `o_bit_cnt`=0, `o_err_cnt`=0; `h`, `g` and all internal counters 0.
- All outputs are registered.
- `o_lock` rises the cycle after the accepted bit that completes `LOCK_CNT` matches. That bit itself is not counted in `o_bit_cnt`.
- `o_lock` falls the cycle after the bit that hits `UNLOCK_ERRS`. That bit is counted in both counters and pulses `o_err`.
- `o_err` and the counter updates appear the cycle after the accepted bit (1-cycle latency).
- Minimum time to lock from reset with error-free input: 9 + `LOCK_CNT` accepted bits (41 at defaults).
- Throughput: 1 bit per clock when `i_valid` is held high.

## Test plan
- Generator (seed 0x1AA, `i_en`=`i_valid`=1) drives the checker: `o_lock` rises after exactly 41 accepted bits. After 1000 more bits, `o_bit_cnt`=1000, `o_err_cnt`=0, and `o_err` never pulses.
- While locked, invert one bit: exactly one `o_err` pulse and `o_err_cnt`=1. `o_lock` stays high and following bits are error-free.
- While locked, invert 8 bits within 64 accepted bits: `o_lock` falls the cycle after the 8th error and `o_err_cnt`=8. It relocks 41 error-free bits later.
- Inject 7 errors in one window and 7 in the next (defaults): lock is held and `o_err_cnt`=14.
- All-zero input for 200 bits: `o_lock` stays 0. Random `i_valid`/`i_en` gaps on a clean stream give the same counts as the gap-free run.
- With `CNT_W`=4, `o_bit_cnt` holds at 15. Assert `i_clr` on an accepted bit: both counters read 0. Assert `i_rst` while locked: all outputs read 0 next cycle and lock needs 41 bits again.

Source files
------------

// File: rtl/prbs9_checker.sv
// PRBS9 (x^9 + x^5 + 1) receive checker: self-synchronizes to the stream, declares lock,
// then free-runs a local reference, counts bit errors and drops lock on dense errors.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_FILL   | shifting the first 9 accepted bits into the history
// ST_SEARCH | predicting from history, counting consecutive correct bits
// ST_LOCKED | free-running local generator, counting bits/errors, windowed unlock
module prbs9_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int WIN_LEN     = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic             i_data,
    input  logic             i_clr,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);
    localparam logic [10:0]      WIN_C   = 11'(WIN_LEN);
    localparam logic [10:0]      UNL_C   = 11'(UNLOCK_ERRS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [8:0]        h_q, h_d;
    logic [8:0]        g_q, g_d;
    logic [3:0]        fill_q, fill_d;
    logic [7:0]        match_q, match_d;
    logic [10:0]       win_bits_q, win_bits_d;
    logic [10:0]       win_errs_q, win_errs_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic        accept;
    logic [8:0]  h_shift;
    logic        p_s;
    logic        p_l;
    logic        bit_err;
    logic [7:0]  match_inc;
    logic [10:0] win_bits_inc;
    logic [10:0] win_errs_inc;

    always_comb begin
        accept       = i_en & i_valid;
        h_shift      = {h_q[7:0], i_data};
        p_s          = h_q[8] ^ h_q[4];
        p_l          = g_q[8] ^ g_q[4];
        bit_err      = i_data ^ p_l;
        match_inc    = (i_data == p_s) ? match_q + 8'd1 : 8'd0;
        win_bits_inc = win_bits_q + 11'd1;
        win_errs_inc = win_errs_q + 11'(bit_err);

        state_d    = state_q;
        h_d        = h_q;
        g_d        = g_q;
        fill_d     = fill_q;
        match_d    = match_q;
        win_bits_d = win_bits_q;
        win_errs_d = win_errs_q;
        lock_d     = lock_q;
        err_d      = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (accept) begin
            case (state_q)
                ST_FILL: begin
                    h_d = h_shift;
                    if (fill_q == 4'd8) begin
                        state_d = ST_SEARCH;
                        fill_d  = 4'd0;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                ST_SEARCH: begin
                    h_d = h_shift;
                    // an all-zero history is the LFSR lock-up state and must never qualify
                    if (h_shift == 9'd0) begin
                        match_d = 8'd0;
                    end else if (match_inc == LOCK_C) begin
                        state_d    = ST_LOCKED;
                        lock_d     = 1'b1;
                        g_d        = h_shift;
                        match_d    = 8'd0;
                        win_bits_d = 11'd0;
                        win_errs_d = 11'd0;
                    end else begin
                        match_d = match_inc;
                    end
                end
                ST_LOCKED: begin
                    // reference advances on its own prediction so a line error is counted once
                    g_d   = {g_q[7:0], p_l};
                    err_d = bit_err;
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (bit_err && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (bit_err && (win_errs_inc == UNL_C)) begin
                        state_d    = ST_FILL;
                        lock_d     = 1'b0;
                        fill_d     = 4'd0;
                        match_d    = 8'd0;
                        win_bits_d = 11'd0;
                        win_errs_d = 11'd0;
                    end else if (win_bits_inc == WIN_C) begin
                        win_bits_d = 11'd0;
                        win_errs_d = 11'd0;
                    end else begin
                        win_bits_d = win_bits_inc;
                        win_errs_d = win_errs_inc;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    lock_d  = 1'b0;
                end
            endcase
        end

        if (i_clr) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_FILL;
            h_q        <= 9'd0;
            g_q        <= 9'd0;
            fill_q     <= 4'd0;
            match_q    <= 8'd0;
            win_bits_q <= 11'd0;
            win_errs_q <= 11'd0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            g_q        <= g_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
            bit_cnt_q  <= bit_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_lock    = lock_q;
    assign o_err     = err_q;
    assign o_bit_cnt = bit_cnt_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// Bench for prbs9_checker: random stimulus, bit-level reference model, scoreboard queue
// drained by a monitor one clock after each issued cycle; a CNT_W=4 copy checks saturation.
module tb_prbs9_checker;

    localparam int LOCK_CNT    = 32;
    localparam int WIN_LEN     = 64;
    localparam int UNLOCK_ERRS = 8;
    localparam longint MAX32   = 64'hFFFF_FFFF;
    localparam int MAX4        = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b0, valid = 1'b0, data = 1'b0, clr = 1'b0;
    logic        lock, err, lock4, err4;
    logic [31:0] bc, ec;
    logic [3:0]  bc4, ec4;

    prbs9_checker dut (
        .clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_data(data), .i_clr(clr),
        .o_lock(lock), .o_err(err), .o_bit_cnt(bc), .o_err_cnt(ec)
    );

    prbs9_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .i_data(data), .i_clr(clr),
        .o_lock(lock4), .o_err(err4), .o_bit_cnt(bc4), .o_err_cnt(ec4)
    );

    typedef struct {
        bit     lock;
        bit     err;
        longint bc;
        longint ec;
        int     bc4;
        int     ec4;
        int     nacc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lock_at = -1;
    int   err_pulses = 0;
    bit   prev_lock = 1'b0;

    // reference model: stream history as bit queues, windows as plain counts
    bit     m_hist[$];
    bit     m_ref[$];
    bit     m_locked = 1'b0;
    int     m_match = 0, m_wb = 0, m_we = 0, m_nacc = 0;
    longint m_bc = 0, m_ec = 0;
    int     m_bc4 = 0, m_ec4 = 0;
    logic [8:0] gen_r = 9'h1AA;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic gen_bit(output bit b);
        b     = gen_r[8];
        gen_r = {gen_r[7:0], gen_r[8] ^ gen_r[4]};
    endtask

    task automatic model(input bit r, input bit acc, input bit d, input bit c);
        exp_t e;
        bit   was_locked, pred, er, any_one;
        er = 1'b0;
        if (r) begin
            m_hist.delete(); m_ref.delete();
            m_locked = 1'b0; m_match = 0; m_wb = 0; m_we = 0; m_nacc = 0;
            m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
        end else begin
            was_locked = m_locked;
            if (acc) begin
                m_nacc++;
                if (!m_locked) begin
                    if (m_hist.size() < 9) begin
                        m_hist.push_back(d);
                    end else begin
                        // m_hist[0] is 9 bits old, m_hist[4] is 5 bits old
                        pred = m_hist[0] ^ m_hist[4];
                        m_match = (d == pred) ? m_match + 1 : 0;
                        void'(m_hist.pop_front());
                        m_hist.push_back(d);
                        any_one = 1'b0;
                        foreach (m_hist[i]) any_one |= m_hist[i];
                        if (!any_one) m_match = 0;
                        if (m_match == LOCK_CNT) begin
                            m_locked = 1'b1;
                            m_ref    = m_hist;
                            m_match  = 0;
                        end
                    end
                end else begin
                    pred = m_ref[0] ^ m_ref[4];
                    void'(m_ref.pop_front());
                    m_ref.push_back(pred);
                    er = (d != pred);
                    m_wb++;
                    if (er) m_we++;
                    if (er && m_we == UNLOCK_ERRS) begin
                        m_locked = 1'b0;
                        m_hist.delete();
                        m_match = 0; m_wb = 0; m_we = 0;
                    end else if (m_wb == WIN_LEN) begin
                        m_wb = 0; m_we = 0;
                    end
                end
            end
            if (c) begin
                m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
            end else if (acc && was_locked) begin
                if (m_bc < MAX32) m_bc++;
                if (m_bc4 < MAX4) m_bc4++;
                if (er && m_ec < MAX32) m_ec++;
                if (er && m_ec4 < MAX4) m_ec4++;
            end
        end
        e.lock = m_locked; e.err = er; e.bc = m_bc; e.ec = m_ec;
        e.bc4 = m_bc4; e.ec4 = m_ec4; e.nacc = m_nacc;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit e_n, input bit v, input bit d, input bit c);
        @(negedge clk);
        rst = r; en = e_n; valid = v; data = d; clr = c;
        model(r, e_n && v, d, c);
    endtask

    task automatic clean(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            cyc(1'b0, 1'b1, 1'b1, b, 1'b0);
        end
    endtask

    task automatic idle_settle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("lock", lock, e.lock);
            chk("err", err, e.err);
            chk("bit_cnt", bc, e.bc);
            chk("err_cnt", ec, e.ec);
            chk("lock4", lock4, e.lock);
            chk("err4", err4, e.err);
            chk("bit_cnt4", bc4, e.bc4);
            chk("err_cnt4", ec4, e.ec4);
            if (!prev_lock && lock) lock_at = e.nacc;
            if (err) err_pulses++;
            prev_lock = lock;
        end
    end

    initial begin
        bit b;
        int pulses0, nacc_clean;
        bit a_en, a_v, a_c;

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_settle();
        chk("reset_lock", lock, 0);
        chk("reset_bit_cnt", bc, 0);
        chk("reset_err_cnt", ec, 0);

        // clean stream from seed 0x1AA: lock after 41 bits, then 1000 error-free bits
        lock_at = -1;
        clean(41 + 1000);
        idle_settle();
        chk("lock_at_41", lock_at, 41);
        chk("clean_bit_cnt", bc, 1000);
        chk("clean_err_cnt", ec, 0);
        chk("clean_no_pulse", err_pulses, 0);
        chk("sat_bit_cnt4", bc4, 15);

        // one inverted bit
        pulses0 = err_pulses;
        gen_bit(b);
        cyc(1'b0, 1'b1, 1'b1, ~b, 1'b0);
        clean(100);
        idle_settle();
        chk("single_err_pulses", err_pulses - pulses0, 1);
        chk("single_err_cnt", ec, 1);
        chk("single_err_lock", lock, 1);

        // clear together with an accepted bit
        gen_bit(b);
        cyc(1'b0, 1'b1, 1'b1, b, 1'b1);
        idle_settle();
        chk("clr_bit_cnt", bc, 0);
        chk("clr_err_cnt", ec, 0);
        chk("clr_lock", lock, 1);

        // 8 errors inside one window -> unlock, then relock 41 clean bits later
        while (m_wb != 0) clean(1);
        for (int i = 0; i < 8; i++) begin
            gen_bit(b);
            cyc(1'b0, 1'b1, 1'b1, ~b, 1'b0);
        end
        idle_settle();
        chk("unlock_lock", lock, 0);
        chk("unlock_err_cnt", ec, 8);
        clean(40);
        idle_settle();
        chk("relock_40", lock, 0);
        clean(1);
        idle_settle();
        chk("relock_41", lock, 1);

        // 7 errors in each of two consecutive windows keeps lock
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        while (m_wb != 0) clean(1);
        for (int i = 0; i < 128; i++) begin
            gen_bit(b);
            cyc(1'b0, 1'b1, 1'b1, b ^ ((i % 64) < 56 && (i % 8) == 0), 1'b0);
        end
        idle_settle();
        chk("two_win_lock", lock, 1);
        chk("two_win_err_cnt", ec, 14);

        // random gaps on a clean stream
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        nacc_clean = 0;
        for (int i = 0; i < 600; i++) begin
            a_en = ($urandom % 4) != 0;
            a_v  = ($urandom % 3) != 0;
            if (a_en && a_v) begin
                gen_bit(b);
                nacc_clean++;
            end else begin
                b = 1'($urandom);
            end
            cyc(1'b0, a_en, a_v, b, 1'b0);
        end
        idle_settle();
        chk("gaps_bit_cnt", bc, nacc_clean);
        chk("gaps_err_cnt", ec, 0);

        // random errors, gaps and clears, checked by the scoreboard alone
        for (int i = 0; i < 3000; i++) begin
            a_en = ($urandom % 8) != 0;
            a_v  = ($urandom % 5) != 0;
            a_c  = ($urandom % 200) == 0;
            if (a_en && a_v) begin
                gen_bit(b);
                b = b ^ (($urandom % 40) == 0);
            end else begin
                b = 1'($urandom);
            end
            cyc(1'b0, a_en, a_v, b, a_c);
        end

        // all-zero input never locks
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_settle();
        chk("zeros_no_lock", lock, 0);

        // reset while locked
        clean(80);
        idle_settle();
        chk("pre_rst_lock", lock, 1);
        gen_bit(b);
        cyc(1'b1, 1'b1, 1'b1, b, 1'b0);
        idle_settle();
        chk("rst_lock", lock, 0);
        chk("rst_err", err, 0);
        chk("rst_bit_cnt", bc, 0);
        chk("rst_err_cnt", ec, 0);
        lock_at = -1;
        clean(60);
        idle_settle();
        chk("rst_relock_at_41", lock_at, 41);

        for (int i = 0; i < 3; i++) idle_settle();
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
